// File: rtl/key_ctrl_pkg.sv
// ============================================================================
// Module  : key_ctrl_pkg
// Brief   : Shared state/owner encodings and default timing for key_repeat_ctrl.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package key_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HOLD   = 2'd1,
      ST_REPEAT = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_INC  = 2'd1,
      OWN_DEC  = 2'd2
   } owner_t;

   localparam int DEF_COUNT_W       = 8;
   localparam int DEF_TIMER_W       = 24;
   localparam int DEF_HOLD_CYCLES   = 12000000;
   localparam int DEF_REPEAT_CYCLES = 3000000;

endpackage

`default_nettype wire

// File: rtl/key_repeat_timer.sv
// ============================================================================
// Module  : key_repeat_timer
// Brief   : Hold/repeat cycle counter with terminal count chosen by phase.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module key_repeat_timer
   import key_ctrl_pkg::*;
#(
   parameter int TIMER_W       = DEF_TIMER_W,
   parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
   parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   input  logic sel_repeat,
   output logic terminal
);

   localparam logic [TIMER_W-1:0] HOLD_LAST   = TIMER_W'(HOLD_CYCLES - 1);
   localparam logic [TIMER_W-1:0] REPEAT_LAST = TIMER_W'(REPEAT_CYCLES - 1);

   logic [TIMER_W-1:0] timer_q;
   logic [TIMER_W-1:0] timer_d;

   always_comb begin
      timer_d = timer_q;
      if (clear) begin
         timer_d = '0;
      end else if (enable) begin
         timer_d = timer_q + TIMER_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         timer_q <= '0;
      end else begin
         timer_q <= timer_d;
      end
   end

   assign terminal = (timer_q == (sel_repeat ? REPEAT_LAST : HOLD_LAST));

endmodule

`default_nettype wire

// File: rtl/key_repeat_ctrl.sv
// ============================================================================
// Module  : key_repeat_ctrl
// Brief   : Button-driven up/down counter with hold-to-repeat and clear.
//           Define KEY_REPEAT_SATURATE_EN to saturate instead of wrapping.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module key_repeat_ctrl
   import key_ctrl_pkg::*;
#(
   parameter int COUNT_W       = DEF_COUNT_W,
   parameter int TIMER_W       = DEF_TIMER_W,
   parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
   parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               inc_down,
   input  logic               inc_up,
   input  logic               dec_down,
   input  logic               dec_up,
   input  logic               clr_down,
   output logic [COUNT_W-1:0] count,
   output logic               step,
   output logic               repeating
);

   state_t             state_q, state_d;
   owner_t             owner_q, owner_d;
   logic [COUNT_W-1:0] count_q, count_d;
   logic               step_q, step_d;
   logic               repeating_q, repeating_d;

   logic               timer_clr;
   logic               timer_en;
   logic               timer_term;

   logic [COUNT_W-1:0] inc_val;
   logic [COUNT_W-1:0] dec_val;
   logic               inc_moves;
   logic               dec_moves;
   logic               owner_up;

   key_repeat_timer #(
      .TIMER_W       (TIMER_W),
      .HOLD_CYCLES   (HOLD_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES)
   ) u_timer (
      .clk        (clk),
      .reset      (reset),
      .clear      (timer_clr),
      .enable     (timer_en),
      .sel_repeat (state_q == ST_REPEAT),
      .terminal   (timer_term)
   );

   // Candidate next values for one step in either direction.
   always_comb begin
      inc_val   = count_q + COUNT_W'(1);
      dec_val   = count_q - COUNT_W'(1);
`ifdef KEY_REPEAT_SATURATE_EN
      inc_moves = (count_q != '1);
      dec_moves = (count_q != '0);
`else
      inc_moves = 1'b1;
      dec_moves = 1'b1;
`endif
      owner_up  = ((owner_q == OWN_INC) && inc_up) ||
                  ((owner_q == OWN_DEC) && dec_up);
   end

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      count_d   = count_q;
      step_d    = 1'b0;
      timer_clr = 1'b0;
      timer_en  = 1'b0;

      if (clr_down) begin
         count_d   = '0;
         step_d    = (count_q != '0);
         state_d   = ST_IDLE;
         owner_d   = OWN_NONE;
         timer_clr = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               timer_clr = 1'b1;
               if (inc_down) begin
                  if (inc_moves) begin
                     count_d = inc_val;
                     step_d  = 1'b1;
                  end
                  owner_d = OWN_INC;
                  state_d = ST_HOLD;
               end else if (dec_down) begin
                  if (dec_moves) begin
                     count_d = dec_val;
                     step_d  = 1'b1;
                  end
                  owner_d = OWN_DEC;
                  state_d = ST_HOLD;
               end
            end
            ST_HOLD, ST_REPEAT: begin
               // Release takes precedence over a timer expiring in the same cycle.
               if (owner_up) begin
                  state_d   = ST_IDLE;
                  owner_d   = OWN_NONE;
                  timer_clr = 1'b1;
               end else if (timer_term) begin
                  if ((owner_q == OWN_INC) && inc_moves) begin
                     count_d = inc_val;
                     step_d  = 1'b1;
                  end else if ((owner_q == OWN_DEC) && dec_moves) begin
                     count_d = dec_val;
                     step_d  = 1'b1;
                  end
                  state_d   = ST_REPEAT;
                  timer_clr = 1'b1;
               end else begin
                  timer_en = 1'b1;
               end
            end
            default: begin
               state_d   = ST_IDLE;
               owner_d   = OWN_NONE;
               timer_clr = 1'b1;
            end
         endcase
      end

      repeating_d = (state_d == ST_REPEAT);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         owner_q     <= OWN_NONE;
         count_q     <= '0;
         step_q      <= 1'b0;
         repeating_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         count_q     <= count_d;
         step_q      <= step_d;
         repeating_q <= repeating_d;
      end
   end

   assign count     = count_q;
   assign step      = step_q;
   assign repeating = repeating_q;

endmodule

`default_nettype wire

// File: tb/tb_key_repeat_ctrl.sv
// ============================================================================
// Module  : tb_key_repeat_ctrl
// Brief   : Directed + randomized bench for key_repeat_ctrl against a
//           countdown-based reference model. Honors KEY_REPEAT_SATURATE_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_key_repeat_ctrl;

   localparam int COUNT_W       = 4;
   localparam int TIMER_W       = 8;
   localparam int HOLD_CYCLES   = 4;
   localparam int REPEAT_CYCLES = 2;
   localparam int MAX_COUNT     = (1 << COUNT_W) - 1;

   logic               clk = 1'b0;
   logic               reset = 1'b0;
   logic               inc_down = 1'b0;
   logic               inc_up = 1'b0;
   logic               dec_down = 1'b0;
   logic               dec_up = 1'b0;
   logic               clr_down = 1'b0;
   logic [COUNT_W-1:0] count;
   logic               step;
   logic               repeating;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: direction held (+1/-1/0), cycles left until next auto step.
   int m_count = 0;
   int m_dir   = 0;
   int m_left  = 0;
   int m_rep   = 0;
   int m_step  = 0;

   key_repeat_ctrl #(
      .COUNT_W       (COUNT_W),
      .TIMER_W       (TIMER_W),
      .HOLD_CYCLES   (HOLD_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .inc_down  (inc_down),
      .inc_up    (inc_up),
      .dec_down  (dec_down),
      .dec_up    (dec_up),
      .clr_down  (clr_down),
      .count     (count),
      .step      (step),
      .repeating (repeating)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_move(input int dir);
`ifdef KEY_REPEAT_SATURATE_EN
      if ((dir > 0 && m_count == MAX_COUNT) || (dir < 0 && m_count == 0)) begin
         return;
      end
`endif
      m_count = (m_count + dir) & MAX_COUNT;
      m_step  = 1;
   endtask

   task automatic model_cycle(input bit rs, input bit id, input bit iu,
                              input bit dd, input bit du, input bit cd);
      m_step = 0;
      if (rs) begin
         m_count = 0; m_dir = 0; m_left = 0; m_rep = 0;
      end else if (cd) begin
         m_step  = (m_count != 0) ? 1 : 0;
         m_count = 0; m_dir = 0; m_rep = 0;
      end else if (m_dir == 0) begin
         if (id) begin
            model_move(1);
            m_dir  = 1;
            m_left = HOLD_CYCLES;
         end else if (dd) begin
            model_move(-1);
            m_dir  = -1;
            m_left = HOLD_CYCLES;
         end
      end else if ((m_dir == 1 && iu) || (m_dir == -1 && du)) begin
         m_dir = 0;
         m_rep = 0;
      end else begin
         m_left--;
         if (m_left == 0) begin
            model_move(m_dir);
            m_left = REPEAT_CYCLES;
            m_rep  = 1;
         end
      end
   endtask

   // One clock: apply inputs at negedge, advance model, check 1 time unit after posedge.
   task automatic cyc(input bit rs, input bit id, input bit iu,
                      input bit dd, input bit du, input bit cd);
      @(negedge clk);
      reset = rs; inc_down = id; inc_up = iu;
      dec_down = dd; dec_up = du; clr_down = cd;
      model_cycle(rs, id, iu, dd, du, cd);
      @(posedge clk);
      #1;
      reset = 0; inc_down = 0; inc_up = 0;
      dec_down = 0; dec_up = 0; clr_down = 0;
      check("count", int'(count), m_count);
      check("step", int'(step), m_step);
      check("repeating", int'(repeating), m_rep);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      // Reset state
      cyc(1, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0);
      check("reset_count_zero", int'(count), 0);

      // Short press
      cyc(0, 1, 0, 0, 0, 0);
      check("press_count_one", int'(count), 1);
      idle(1);
      cyc(0, 0, 1, 0, 0, 0);
      idle(3);

      // Long hold into repeat, then release
      cyc(0, 0, 0, 0, 0, 1);
      cyc(0, 1, 0, 0, 0, 0);
      idle(11);
      cyc(0, 0, 1, 0, 0, 0);
      idle(5);

      // Decrement from 0 (wrap or saturate), then increment back
      cyc(0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 1, 0, 0);
      check("dec_at_zero", int'(count),
`ifdef KEY_REPEAT_SATURATE_EN
            0
`else
            MAX_COUNT
`endif
      );
      cyc(0, 0, 0, 0, 1, 0);

      // Climb to max then increment once more
      cyc(0, 0, 0, 0, 0, 1);
      for (int i = 0; i < MAX_COUNT; i++) begin
         cyc(0, 1, 0, 0, 0, 0);
         cyc(0, 0, 1, 0, 0, 0);
      end
      cyc(0, 1, 0, 0, 0, 0);
      check("inc_at_max", int'(count),
`ifdef KEY_REPEAT_SATURATE_EN
            MAX_COUNT
`else
            0
`endif
      );
      cyc(0, 0, 1, 0, 0, 0);

      // Simultaneous inc/dec, foreign pulses during hold, stray dec_up
      cyc(0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 1, 0);
      cyc(0, 1, 0, 1, 0, 0);
      cyc(0, 0, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 1, 0);
      idle(6);
      cyc(0, 0, 1, 0, 0, 0);

      // Clear during repeat at non-zero count, then clear at zero
      cyc(0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 8; i++) begin
         cyc(0, 1, 0, 0, 0, 0);
         cyc(0, 0, 1, 0, 0, 0);
      end
      cyc(0, 1, 0, 0, 0, 0);
      idle(6);
      cyc(0, 0, 0, 0, 0, 1);
      check("clear_in_repeat", int'(count), 0);
      idle(8);
      cyc(0, 0, 0, 0, 0, 1);
      idle(2);

      // Reset while repeating, then an orphan release
      cyc(0, 1, 0, 0, 0, 0);
      idle(7);
      cyc(1, 0, 0, 0, 0, 0);
      idle(2);
      cyc(0, 0, 1, 0, 0, 0);
      idle(4);

      // Randomized traffic
      for (int i = 0; i < 4000; i++) begin
         cyc(($urandom_range(0, 299) == 0),
             ($urandom_range(0, 11) == 0),
             ($urandom_range(0, 13) == 0),
             ($urandom_range(0, 11) == 0),
             ($urandom_range(0, 13) == 0),
             ($urandom_range(0, 59) == 0));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
